uc_engine_sched: RTL
====================

Name: uc_engine_sched

Overview:
- Schedules unit-clause (UC) literals into the single UCQ write port.
- Sources: the memory loader during initial load, then NUM_ENGINE BCP engines under round-robin arbitration.
- Keeps a per-variable assignment bitmap. Duplicate literals are filtered out. A literal whose negation is already assigned raises a sticky conflict that halts scheduling until restart.

Parameters:
- UC_LENGTH, 1024, number of variable slots; legal variable indices are 1..UC_LENGTH-1.
- NUM_ENGINE, 4, number of engine requesters.
- LIT_W, $clog2(UC_LENGTH)+1, signed literal width (11 at default).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- restart  in  1  one-cycle pulse that starts a new solve
- mem_valid  in  1  memory literal valid
- mem_lit  in  LIT_W  memory literal (signed)
- mem_done  in  1  memory load finished (level)
- mem_ready  out  1  memory literal accepted this cycle when mem_valid=1
- eng_valid  in  NUM_ENGINE  per-engine request
- eng_lit  in  NUM_ENGINE*LIT_W  per-engine literal; engine i uses bits [i*LIT_W +: LIT_W]
- eng_ready  out  NUM_ENGINE  one-hot grant/accept
- ucq_valid  out  1  output stage holds a literal
- ucq_lit  out  LIT_W  literal toward the UCQ
- ucq_ready  in  1  UCQ not full
- conflict  out  1  sticky conflict flag
- conflict_lit  out  LIT_W  literal that caused the conflict
- busy  out  1  high while in CLEAR
- err_illegal  out  1  one-cycle pulse when an illegal literal is consumed

Behaviour:
- Reset values: all outputs 0, except busy=1. State=CLEAR, clear counter=0, rr_ptr=0, output stage empty.
- States:
  - CLEAR: sweeps the bitmap, clearing one variable per cycle for UC_LENGTH cycles; busy=1. Goes to LOAD after index UC_LENGTH-1 is cleared. The bitmap itself has no reset; CLEAR is its only initialisation.
  - LOAD: only the memory source is eligible; eng_ready=0. Goes to ARB on a cycle with mem_done=1 and mem_valid=0. If mem_valid and mem_done are both high, the literal is accepted and the block stays in LOAD.
  - ARB: only engines are eligible; mem_ready=0.
  - CONFLICT: all readies are 0; the output stage still drains.
- restart in any state: go to CLEAR, invalidate the output stage, clear conflict and conflict_lit, set rr_ptr=0. Same behaviour on reset mid-operation.
- Accept enable: state is LOAD or ARB, and the output stage is empty or ucq_ready=1. At most one literal is accepted per cycle. A transfer occurs when valid and ready are both high at the rising edge.
- Round-robin: the grant goes to the first engine with eng_valid=1, searching upward from rr_ptr and wrapping modulo NUM_ENGINE. After a grant, rr_ptr = grant+1 (mod NUM_ENGINE). rr_ptr does not move when there is no grant.
- Grant is combinational from eng_valid; an engine holds valid and its literal until it sees ready.
- Classification of an accepted literal L, with v=|L| and polarity p = (L>0):
  - Illegal (L==0 or L==-UC_LENGTH): consumed, not forwarded; err_illegal pulses the next cycle.
  - New (v unassigned): bitmap[v] set to assigned with polarity p; L is registered into the output stage. Latency 1: ucq_valid=1 and ucq_lit=L on the next cycle.
  - Duplicate (v assigned, same polarity): consumed, dropped, no stall.
  - Conflict (v assigned, opposite polarity): consumed, not forwarded. Next cycle: conflict=1, conflict_lit=L, state=CONFLICT.
- Output stage: ucq_valid stays high and ucq_lit stays stable until ucq_ready=1. It is refilled in the same cycle it drains.
- Width rule: |L| is computed in LIT_W+1 bits, so the -UC_LENGTH encoding can be detected without overflow.

Optional Feature:
- Macro UC_SCHED_STATS_EN.
- Defined:
  - Adds output ports fwd_cnt, dup_cnt and grant_cnt, each 16 bits.
  - fwd_cnt counts literals forwarded; dup_cnt counts duplicates dropped.
  - grant_cnt is a NUM_ENGINE x 16 array counting grants per engine.
  - All counters saturate, reset to 0, and clear on restart.
- Not defined: these ports and their logic are absent.

Test Plan:
- Reset and clear: hold rst=0 for 3 cycles, then release. Required: all outputs 0, busy=1 for exactly 1024 cycles, then busy=0 and mem_ready=1 once mem_valid=1.
- Memory load: with ucq_ready=1, send mem_lit 1 then 5, then mem_done=1. Required: ucq_lit 1 then 5, each one cycle after acceptance; state moves to ARB; eng_ready=0 during LOAD.
- Round-robin and conflict: after that load, all engines hold valid with eng_lit 2, 4, 3, -2. Required:
  - eng_ready grants e0, e1, e2, e3 on consecutive cycles.
  - ucq_lit sequence is 2, 4, 3.
  - -2 produces conflict=1 and conflict_lit=-2; all readies then stay 0.
  - A restart pulse clears conflict, busy=1, and the sweep runs again.
- Duplicate filtering: in ARB, engine 1 sends 7 twice. Required: one ucq_valid pulse with 7; the second is accepted with no ucq_valid; no stall.
- Backpressure: ucq_ready=0, then engine 0 sends 9 and engine 2 sends 11. Required:
  - 9 is held on ucq_lit with ucq_valid=1; eng_ready=0 while the stage is full.
  - When ucq_ready=1, 11 is accepted in the same cycle 9 drains.
- Illegal literal: engine 3 sends 0, then -1024. Required: two err_illegal pulses, no ucq_valid, bitmap unchanged (a later 1 still forwards if variable 1 is free).

Source files
------------

// File: rtl/uc_engine_sched.sv
`default_nettype none
// ============================================================================
// Module   : uc_engine_sched
// Purpose  : Funnels unit-clause literals into the single UCQ write port.
//            The memory loader feeds literals during the initial load, then
//            NUM_ENGINE BCP engines share the port under round-robin
//            arbitration. A per-variable assignment bitmap drops duplicate
//            literals and flags a sticky conflict when a literal contradicts
//            an earlier assignment.
// Ports    : clk, rst (async, active-low), restart (new-solve pulse)
//            mem_valid/mem_lit/mem_done/mem_ready   - loader interface
//            eng_valid/eng_lit/eng_ready            - engine requests/grants
//            ucq_valid/ucq_lit/ucq_ready            - UCQ write port
//            conflict/conflict_lit                  - sticky conflict report
//            busy (bitmap sweep running), err_illegal (illegal literal pulse)
// Options  : `define UC_SCHED_STATS_EN adds fwd_cnt, dup_cnt and grant_cnt
//            saturating statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module uc_engine_sched #(
    parameter int UC_LENGTH  = 1024,
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = $clog2(UC_LENGTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        restart,
    input  logic                        mem_valid,
    input  logic [LIT_W-1:0]            mem_lit,
    input  logic                        mem_done,
    output logic                        mem_ready,
    input  logic [NUM_ENGINE-1:0]       eng_valid,
    input  logic [NUM_ENGINE*LIT_W-1:0] eng_lit,
    output logic [NUM_ENGINE-1:0]       eng_ready,
    output logic                        ucq_valid,
    output logic [LIT_W-1:0]            ucq_lit,
    input  logic                        ucq_ready,
    output logic                        conflict,
    output logic [LIT_W-1:0]            conflict_lit,
    output logic                        busy,
    output logic                        err_illegal
`ifdef UC_SCHED_STATS_EN
    ,
    output logic [15:0]                 fwd_cnt,
    output logic [15:0]                 dup_cnt,
    output logic [NUM_ENGINE-1:0][15:0] grant_cnt
`endif
);

    localparam int                 c_IDX_W    = $clog2(UC_LENGTH);
    localparam int                 c_PTR_W    = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam logic [LIT_W:0]     c_UC_LEN   = (LIT_W + 1)'(UC_LENGTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(UC_LENGTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR    = 2'd0,
        S_LOAD     = 2'd1,
        S_ARB      = 2'd2,
        S_CONFLICT = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_clr_idx;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic                 r_ucq_valid;
    logic [LIT_W-1:0]     r_ucq_lit;
    logic                 r_conflict;
    logic [LIT_W-1:0]     r_conflict_lit;
    logic                 r_err;
    // Assignment bitmap: assigned flag and polarity per variable. No reset;
    // the CLEAR sweep is its only initialisation.
    logic [UC_LENGTH-1:0] r_asg;
    logic [UC_LENGTH-1:0] r_pol;

    logic [LIT_W-1:0]     w_eng_lit_arr [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] w_gnt;
    logic [c_PTR_W-1:0]   w_gnt_idx;
    logic                 w_gnt_any;
    logic [c_PTR_W-1:0]   w_rr_next;
    logic                 w_acc_en;
    logic                 w_mem_take;
    logic                 w_eng_take;
    logic                 w_take;
    logic [LIT_W-1:0]     w_lit;
    logic [LIT_W:0]       w_lit_ext;
    logic [LIT_W:0]       w_abs;
    logic [c_IDX_W-1:0]   w_var;
    logic                 w_pol;
    logic                 w_legal;
    logic                 w_is_new;
    logic                 w_is_dup;
    logic                 w_is_conf;

    generate
        for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_unpack
            assign w_eng_lit_arr[g] = eng_lit[g*LIT_W +: LIT_W];
        end
    endgenerate

    // Round-robin search starting at r_rr_ptr; first requester found wins.
    always_comb begin : p_grant
        int v_idx;
        v_idx     = 0;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_ENGINE) begin
                v_idx = v_idx - NUM_ENGINE;
            end
            if (!w_gnt_any && eng_valid[c_PTR_W'(v_idx)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = c_PTR_W'(v_idx);
            end
        end
        if (w_gnt_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_rr_next = (w_gnt_idx == c_PTR_W'(NUM_ENGINE - 1)) ? '0 : w_gnt_idx + c_PTR_W'(1);

    // restart blocks acceptance so no literal is consumed and then lost.
    assign w_acc_en   = ((r_state == S_LOAD) || (r_state == S_ARB)) &&
                        (!r_ucq_valid || ucq_ready) && !restart;
    assign mem_ready  = w_acc_en && (r_state == S_LOAD);
    assign eng_ready  = (w_acc_en && (r_state == S_ARB)) ? w_gnt : '0;
    assign w_mem_take = mem_ready && mem_valid;
    assign w_eng_take = |eng_ready;
    assign w_take     = w_mem_take || w_eng_take;
    assign w_lit      = w_mem_take ? mem_lit : w_eng_lit_arr[w_gnt_idx];

    // Magnitude in one extra bit so -UC_LENGTH does not wrap onto itself.
    assign w_lit_ext  = {w_lit[LIT_W-1], w_lit};
    assign w_abs      = w_lit[LIT_W-1] ? -w_lit_ext : w_lit_ext;
    assign w_legal    = (w_abs != '0) && (w_abs < c_UC_LEN);
    assign w_var      = w_abs[c_IDX_W-1:0];
    assign w_pol      = ~w_lit[LIT_W-1];
    assign w_is_new   = w_legal && !r_asg[w_var];
    assign w_is_dup   = w_legal && r_asg[w_var] && (r_pol[w_var] == w_pol);
    assign w_is_conf  = w_legal && r_asg[w_var] && (r_pol[w_var] != w_pol);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_CLEAR;
            r_clr_idx      <= '0;
            r_rr_ptr       <= '0;
            r_ucq_valid    <= 1'b0;
            r_ucq_lit      <= '0;
            r_conflict     <= 1'b0;
            r_conflict_lit <= '0;
            r_err          <= 1'b0;
        end else if (restart) begin
            r_state        <= S_CLEAR;
            r_clr_idx      <= '0;
            r_rr_ptr       <= '0;
            r_ucq_valid    <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_lit <= '0;
            r_err          <= 1'b0;
        end else begin
            r_err <= w_take && !w_legal;
            if (w_eng_take) begin
                r_rr_ptr <= w_rr_next;
            end
            // Output stage refills in the same cycle it drains.
            if (w_take && w_is_new) begin
                r_ucq_valid <= 1'b1;
                r_ucq_lit   <= w_lit;
            end else if (ucq_ready) begin
                r_ucq_valid <= 1'b0;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + c_IDX_W'(1);
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (mem_done && !mem_valid) begin
                        r_state <= S_ARB;
                    end
                end
                default: begin
                end
            endcase
            if (w_take && w_is_conf) begin
                r_conflict     <= 1'b1;
                r_conflict_lit <= w_lit;
                r_state        <= S_CONFLICT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_asg[r_clr_idx] <= 1'b0;
            r_pol[r_clr_idx] <= 1'b0;
        end else if (w_take && w_is_new) begin
            r_asg[w_var] <= 1'b1;
            r_pol[w_var] <= w_pol;
        end
    end

    assign ucq_valid    = r_ucq_valid;
    assign ucq_lit      = r_ucq_lit;
    assign conflict     = r_conflict;
    assign conflict_lit = r_conflict_lit;
    assign busy         = (r_state == S_CLEAR);
    assign err_illegal  = r_err;

`ifdef UC_SCHED_STATS_EN
    logic [15:0]                 r_fwd_cnt;
    logic [15:0]                 r_dup_cnt;
    logic [NUM_ENGINE-1:0][15:0] r_grant_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_cnt <= '0;
            r_dup_cnt <= '0;
        end else if (restart) begin
            r_fwd_cnt <= '0;
            r_dup_cnt <= '0;
        end else begin
            // A literal counts as forwarded when the UCQ actually takes it.
            if (r_ucq_valid && ucq_ready && (r_fwd_cnt != 16'hFFFF)) begin
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
            end
            if (w_take && w_is_dup && (r_dup_cnt != 16'hFFFF)) begin
                r_dup_cnt <= r_dup_cnt + 16'd1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_grant_cnt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_grant_cnt[g] <= '0;
                end else if (restart) begin
                    r_grant_cnt[g] <= '0;
                end else if (eng_ready[g] && (r_grant_cnt[g] != 16'hFFFF)) begin
                    r_grant_cnt[g] <= r_grant_cnt[g] + 16'd1;
                end
            end
        end
    endgenerate

    assign fwd_cnt   = r_fwd_cnt;
    assign dup_cnt   = r_dup_cnt;
    assign grant_cnt = r_grant_cnt;
`endif

endmodule
`default_nettype wire
